// File: rtl/status_flag_unit.sv
// NZCV status register (CPSR flags) with a one-deep saved copy (SPSR) for exception
// entry/return, plus a forwarded flag view for the ID-stage condition check.
module status_flag_unit #(
  parameter bit FORWARD_EN = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       exe_valid,
  input  logic       exe_s,
  input  logic [3:0] exe_flags,
  input  logic       exc_enter,
  input  logic       exc_return,
  output logic [3:0] sr_flags,
  output logic [3:0] id_flags,
  output logic [3:0] spsr_flags,
  output logic       spsr_valid,
  output logic       exc_nest_err
);

  logic       upd;
  logic       ret_ok;
  logic       enter_ok;
  logic       nest_err_set;
  logic [3:0] nxt;
  logic [3:0] cpsr_next;

  // Flags are {N,Z,C,V}; a bubble or flushed slot (exe_valid=0) never touches state.
  assign upd       = exe_valid & exe_s;
  assign ret_ok    = exc_return & spsr_valid;
  assign enter_ok  = exc_enter & ~exc_return & ~spsr_valid;
  assign nxt       = upd ? exe_flags : sr_flags;
  assign cpsr_next = ret_ok ? spsr_flags : nxt;

  // Nested entry, unmatched return, or enter+return together are all protocol errors.
  assign nest_err_set = (exc_enter & spsr_valid)
                      | (exc_return & ~spsr_valid)
                      | (exc_enter & exc_return);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sr_flags <= 4'b0000;
    end else begin
      sr_flags <= cpsr_next;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      spsr_flags <= 4'b0000;
      spsr_valid <= 1'b0;
    end else if (ret_ok) begin
      spsr_valid <= 1'b0;
    end else if (enter_ok) begin
      spsr_flags <= nxt;
      spsr_valid <= 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      exc_nest_err <= 1'b0;
    end else if (nest_err_set) begin
      exc_nest_err <= 1'b1;
    end
  end

  // With forwarding, ID sees exactly what sr_flags will hold after the next edge.
  generate
    if (FORWARD_EN) begin : g_fwd
      assign id_flags = cpsr_next;
    end else begin : g_nofwd
      assign id_flags = sr_flags;
    end
  endgenerate

endmodule
